pico_mips_core: RTL and testbench
=================================

PICO_MIPS_CORE -- requirements
Module: pico_mips_core

Interface
REQ-001 SHALL have parameter N, default 8, datapath/register/LED width; legal range 8..16.
REQ-002 SHALL have parameter R_SIZE, default 3, register-address width, giving 2^R_SIZE registers.
REQ-003 SHALL have parameter P_SIZE, default 5, program-counter width.
REQ-004 SHALL derive I_SIZE = 4 + 2*R_SIZE + N as the instruction width, with fields opcode[I_SIZE-1 -: 4], rd, rs, imm[N-1:0], MSB to LSB.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-006 SHALL have port nReset, input, 1 bit: reset is synchronous and active-low.
REQ-007 SHALL have port SW, input, 10 bits: SW[7:0] is data, SW[8] is the handshake key, SW[9] is unused.
REQ-008 SHALL have port instr, input, I_SIZE bits: combinational program-ROM data addressed by pc.
REQ-009 SHALL have port pc, output, P_SIZE bits: program-ROM address, driven directly from a register.
REQ-010 SHALL have port LED, output, N bits: registered result display.
REQ-011 SHALL have port halted, output, 1 bit: high while the core is in HALT.

Function
REQ-012 SHALL use a Moore FSM with states FETCH, EXEC, WAIT_PRESS, WAIT_RELEASE and HALT.
REQ-013 SHALL, in FETCH, latch instr into an instruction register and then go to EXEC.
REQ-014 SHALL, in EXEC, perform the operation and go to FETCH, giving 2 cycles per instruction except WAIT and HALT.
REQ-015 SHALL update pc in EXEC to pc+1 modulo 2^P_SIZE (2^P_SIZE-1 wraps to 0), unless a branch is taken.
REQ-016 SHALL implement opcodes as follows:
- 0 NOP
- 1 ADD: rd=rd+rs
- 2 ADDI: rd=rd+imm
- 3 SUB: rd=rd-rs
- 4 MULF: P=signed(rd)*signed(rs) as 2N bits; rd=P[2N-2:N-1]
- 5 LDSW: rd=sign-extended SW[7:0]
- 6 OUT: LED=rd
- 7 WAIT
- 8 BZ: if rd==0 then pc=imm[P_SIZE-1:0]
- 9 JMP: pc=imm[P_SIZE-1:0]
- 10 HALT
- 11..15 SHALL behave as NOP
REQ-017 SHALL keep all arithmetic modulo 2^N with overflow discarded and no flags.
REQ-018 SHALL hardwire register 0 to zero: writes are ignored and reads return 0.
REQ-019 SHALL read both operands before writing in the same EXEC, so rd==rs uses the old value.
REQ-020 SHALL, on WAIT, go from EXEC to WAIT_PRESS, where SW[8]==1 moves to WAIT_RELEASE.
REQ-021 SHALL, in WAIT_RELEASE, move to FETCH with pc+1 when SW[8]==0.
REQ-022 SHALL treat SW[8] already high on entry as a press (WAIT_PRESS lasts 1 cycle) and leave SW unsynchronised.
REQ-023 SHALL hold pc, registers and LED in HALT, with halted=1; only reset exits HALT.
REQ-024 SHALL leave LED changed only by OUT, with the new value visible the cycle after EXEC.

Reset
REQ-025 SHALL, when nReset==0 at a clk edge, set state=FETCH, pc=0, LED=0, halted=0, instruction register=0 and all registers=0.
REQ-026 SHALL let reset override every state, including WAIT_* and HALT, and discard any in-flight EXEC.

Configuration
REQ-027 SHALL, when DEMO_MODE_EN is defined, add outputs displayPC (P_SIZE bits, equal to pc) and displayOpCode (4 bits, latched opcode).
REQ-028 SHALL, when DEMO_MODE_EN is defined, add output clkLED (1 bit, equal to clk).
REQ-029 SHALL, without DEMO_MODE_EN, omit those ports and leave all other behaviour identical.

Verification
REQ-030 SHALL cover: reset mid-EXEC of ADDI r1,5 -> next cycle pc=0, LED=0, r1=0, state FETCH.
REQ-031 SHALL cover: LDSW r1 (SW=0x03), ADDI r1,0x7F, OUT r1 -> LED=0x82 six cycles after first FETCH.
REQ-032 SHALL cover: MULF with r1=0x40, r2=0x40 (N=8) -> r1=0x20; and r1=0x80, r2=0x80 -> r1=0x80 (wrap).
REQ-033 SHALL cover: WAIT with SW[8] low for 10 cycles, high for 3, then low -> pc advances only after the release cycle.
REQ-034 SHALL cover: JMP at pc=31 with imm=0, then a NOP at 31 (P_SIZE=5) -> pc=0 both times; BZ r0 -> always taken.
REQ-035 SHALL cover: HALT -> halted=1 with pc frozen for 20 cycles; nReset low -> halted=0, pc=0.

Source files
------------

// File: rtl/pico_mips_core.sv
// pico_mips_core: multi-cycle accumulator-style MIPS-like core with an external program ROM.
// Define DEMO_MODE_EN to add the displayPC / displayOpCode / clkLED board-debug outputs.
module pico_mips_core #(
    parameter  int N      = 8,
    parameter  int R_SIZE = 3,
    parameter  int P_SIZE = 5,
    localparam int I_SIZE = 4 + 2*R_SIZE + N
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic [9:0]        SW,
    input  logic [I_SIZE-1:0] instr,
    output logic [P_SIZE-1:0] pc,
    output logic [N-1:0]      LED,
    output logic              halted
`ifdef DEMO_MODE_EN
    ,
    output logic [P_SIZE-1:0] displayPC,
    output logic [3:0]        displayOpCode,
    output logic              clkLED
`endif
);

    localparam int NREGS = 1 << R_SIZE;
    localparam int PW    = 2 * N;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_ADDI = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_MULF = 4'd4;
    localparam logic [3:0] OP_LDSW = 4'd5;
    localparam logic [3:0] OP_OUT  = 4'd6;
    localparam logic [3:0] OP_WAIT = 4'd7;
    localparam logic [3:0] OP_BZ   = 4'd8;
    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_HALT = 4'd10;

    typedef enum logic [2:0] {
        FETCH,
        EXEC,
        WAIT_PRESS,
        WAIT_RELEASE,
        HALT
    } state_t;

    state_t              state_q, state_d;
    logic [P_SIZE-1:0]   pc_q, pc_d;
    logic [N-1:0]        led_q, led_d;
    logic [I_SIZE-1:0]   ir_q, ir_d;

    logic [3:0]          op;
    logic [R_SIZE-1:0]   rd_a;
    logic [R_SIZE-1:0]   rs_a;
    logic [N-1:0]        imm;
    logic [N-1:0]        rd_val;
    logic [N-1:0]        rs_val;
    logic [N-1:0]        rf_val [NREGS];
    logic                wr_en;
    logic [N-1:0]        wr_data;
    logic [P_SIZE-1:0]   pc_inc;
    logic [N-1:0]        sw_ext;
    logic signed [PW-1:0] mul_a, mul_b, prod;
    logic [N-1:0]        mulf_res;
    logic [N-1:0]        mul_unused;
    logic                sw_unused;

    assign op     = ir_q[I_SIZE-1 -: 4];
    assign rd_a   = ir_q[I_SIZE-5 -: R_SIZE];
    assign rs_a   = ir_q[I_SIZE-5-R_SIZE -: R_SIZE];
    assign imm    = ir_q[N-1:0];

    // Operands come straight from the current register values, so rd==rs sees the old value.
    assign rd_val = rf_val[rd_a];
    assign rs_val = rf_val[rs_a];

    assign pc_inc = pc_q + P_SIZE'(1);
    assign sw_ext = N'($signed(SW[7:0]));

    // Q1.(N-1) fractional multiply: keep the middle N bits of the 2N-bit product.
    assign mul_a      = PW'($signed(rd_val));
    assign mul_b      = PW'($signed(rs_val));
    assign prod       = mul_a * mul_b;
    assign mulf_res   = prod[PW-2:N-1];
    assign mul_unused = {prod[PW-1], prod[N-2:0]};
    assign sw_unused  = SW[9];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        led_d   = led_q;
        ir_d    = ir_q;
        wr_en   = 1'b0;
        wr_data = '0;
        case (state_q)
            FETCH: begin
                ir_d    = instr;
                state_d = EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                pc_d    = pc_inc;
                case (op)
                    OP_ADD: begin
                        wr_en   = 1'b1;
                        wr_data = rd_val + rs_val;
                    end
                    OP_ADDI: begin
                        wr_en   = 1'b1;
                        wr_data = rd_val + imm;
                    end
                    OP_SUB: begin
                        wr_en   = 1'b1;
                        wr_data = rd_val - rs_val;
                    end
                    OP_MULF: begin
                        wr_en   = 1'b1;
                        wr_data = mulf_res;
                    end
                    OP_LDSW: begin
                        wr_en   = 1'b1;
                        wr_data = sw_ext;
                    end
                    OP_OUT: begin
                        led_d = rd_val;
                    end
                    OP_WAIT: begin
                        state_d = WAIT_PRESS;
                        pc_d    = pc_q;
                    end
                    OP_BZ: begin
                        if (rd_val == '0) begin
                            pc_d = imm[P_SIZE-1:0];
                        end
                    end
                    OP_JMP: begin
                        pc_d = imm[P_SIZE-1:0];
                    end
                    OP_HALT: begin
                        state_d = HALT;
                        pc_d    = pc_q;
                    end
                    default: begin
                    end
                endcase
            end
            WAIT_PRESS: begin
                if (SW[8]) begin
                    state_d = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                // The program resumes only once the key has been let go.
                if (!SW[8]) begin
                    state_d = FETCH;
                    pc_d    = pc_inc;
                end
            end
            HALT: begin
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q <= FETCH;
            pc_q    <= '0;
            led_q   <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            led_q   <= led_d;
            ir_q    <= ir_d;
        end
    end

    // Register file: entry 0 is a constant zero, the others are individually enabled flops.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_regs
            if (gi == 0) begin : g_zero
                assign rf_val[gi] = '0;
            end else begin : g_reg
                logic [N-1:0] val_q, val_d;

                always_comb begin
                    val_d = val_q;
                    if (wr_en && (rd_a == R_SIZE'(gi))) begin
                        val_d = wr_data;
                    end
                end

                always_ff @(posedge clk) begin
                    if (!nReset) begin
                        val_q <= '0;
                    end else begin
                        val_q <= val_d;
                    end
                end

                assign rf_val[gi] = val_q;
            end
        end
    endgenerate

    assign pc     = pc_q;
    assign LED    = led_q;
    assign halted = (state_q == HALT);

`ifdef DEMO_MODE_EN
    assign displayPC     = pc_q;
    assign displayOpCode = ir_q[I_SIZE-1 -: 4];
    assign clkLED        = clk;
`endif

endmodule

// File: tb/tb_pico_mips_core.sv
// Self-checking bench for pico_mips_core: directed scenarios plus random programs
// compared against an instruction-level interpreter of the ISA.
module tb_pico_mips_core;

    localparam int N = 8;
    localparam int R = 3;
    localparam int P = 5;
    localparam int I = 4 + 2*R + N;

    logic         clk = 1'b0;
    logic         nReset = 1'b0;
    logic [9:0]   SW = '0;
    logic [I-1:0] instr;
    logic [P-1:0] pc;
    logic [N-1:0] LED;
    logic         halted;

    logic [I-1:0] rom [32];
    assign instr = rom[pc];

    always #5 clk = ~clk;

    pico_mips_core #(.N(N), .R_SIZE(R), .P_SIZE(P)) dut (
        .clk    (clk),
        .nReset (nReset),
        .SW     (SW),
        .instr  (instr),
        .pc     (pc),
        .LED    (LED),
        .halted (halted)
    );

    int checks = 0;
    int errors = 0;

    // Architectural model: eight 8-bit registers, program counter, LED.
    int m_reg [8];
    int m_pc;
    int m_led;

    function automatic logic [I-1:0] enc(input int op, input int rd, input int rs, input int imm);
        return {op[3:0], rd[2:0], rs[2:0], imm[7:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 32; i++) rom[i] = '0;
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        tick(2);
        nReset = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 0;
        m_pc  = 0;
        m_led = 0;
    endtask

    // Executes one instruction from rom at the model pc using plain integer arithmetic.
    task automatic model_step();
        logic [I-1:0] w;
        int op, rd, rs, imm, a, b, sa, sb, res, nxt;
        w   = rom[m_pc];
        op  = int'(w[17:14]);
        rd  = int'(w[13:11]);
        rs  = int'(w[10:8]);
        imm = int'(w[7:0]);
        a   = m_reg[rd];
        b   = m_reg[rs];
        res = -1;
        nxt = (m_pc + 1) % 32;
        case (op)
            1: res = (a + b) % 256;
            2: res = (a + imm) % 256;
            3: res = (a - b + 256) % 256;
            4: begin
                sa  = (a >= 128) ? a - 256 : a;
                sb  = (b >= 128) ? b - 256 : b;
                res = ((sa * sb) >>> 7) & 255;
            end
            5: res = int'(SW[7:0]);
            6: m_led = a;
            8: if (a == 0) nxt = imm % 32;
            9: nxt = imm % 32;
            default: ;
        endcase
        if (res >= 0 && rd != 0) m_reg[rd] = res;
        m_pc = nxt;
    endtask

    initial begin
        // Reset state
        rom_clear();
        do_reset();
        check("reset_pc", 32'(pc), 32'(0));
        check("reset_led", 32'(LED), 32'(0));
        check("reset_halted", 32'(halted), 32'(0));

        // LDSW / ADDI / OUT chain, then HALT and reset out of HALT
        rom_clear();
        rom[0] = enc(5, 1, 0, 0);
        rom[1] = enc(2, 1, 0, 8'h7F);
        rom[2] = enc(6, 1, 0, 0);
        rom[3] = enc(10, 0, 0, 0);
        SW = 10'h003;
        do_reset();
        tick(5);
        check("led_before_out", 32'(LED), 32'(0));
        tick(1);
        check("led_0x82", 32'(LED), 32'(8'h82));
        check("pc_after_out", 32'(pc), 32'(3));
        tick(2);
        check("halted_set", 32'(halted), 32'(1));
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("halt_pc_frozen", 32'(pc), 32'(3));
            check("halt_stays", 32'(halted), 32'(1));
        end
        check("halt_led_held", 32'(LED), 32'(8'h82));
        nReset = 1'b0;
        tick(1);
        check("halt_reset_halted", 32'(halted), 32'(0));
        check("halt_reset_pc", 32'(pc), 32'(0));
        check("halt_reset_led", 32'(LED), 32'(0));
        nReset = 1'b1;
        $display("step: ldsw/addi/out/halt sequence done");

        // Reset during EXEC of ADDI r1,5 discards it and clears r1
        rom_clear();
        rom[0] = enc(2, 1, 0, 5);
        rom[1] = enc(2, 1, 0, 5);
        do_reset();
        tick(3);
        nReset = 1'b0;
        tick(1);
        check("midexec_pc", 32'(pc), 32'(0));
        check("midexec_led", 32'(LED), 32'(0));
        nReset = 1'b1;
        rom[0] = enc(2, 1, 0, 1);
        rom[1] = enc(6, 1, 0, 0);
        rom[2] = enc(10, 0, 0, 0);
        tick(4);
        check("midexec_r1_cleared", 32'(LED), 32'(1));
        check("midexec_pc_after", 32'(pc), 32'(2));
        $display("step: reset mid-EXEC done");

        // MULF, rd==rs read-before-write, r0 hardwired
        rom_clear();
        rom[0]  = enc(2, 1, 0, 8'h40);
        rom[1]  = enc(2, 2, 0, 8'h40);
        rom[2]  = enc(4, 1, 2, 0);
        rom[3]  = enc(6, 1, 0, 0);
        rom[4]  = enc(2, 1, 0, 8'h60);
        rom[5]  = enc(2, 2, 0, 8'h40);
        rom[6]  = enc(4, 1, 2, 0);
        rom[7]  = enc(6, 1, 0, 0);
        rom[8]  = enc(2, 3, 0, 8'h21);
        rom[9]  = enc(1, 3, 3, 0);
        rom[10] = enc(6, 3, 0, 0);
        rom[11] = enc(2, 0, 0, 5);
        rom[12] = enc(6, 0, 0, 0);
        rom[13] = enc(10, 0, 0, 0);
        do_reset();
        tick(8);
        check("mulf_0x40", 32'(LED), 32'(8'h20));
        tick(8);
        check("mulf_0x80_wrap", 32'(LED), 32'(8'h80));
        tick(6);
        check("add_rd_eq_rs", 32'(LED), 32'(8'h42));
        tick(4);
        check("r0_reads_zero", 32'(LED), 32'(0));
        tick(2);
        check("mulf_prog_halted", 32'(halted), 32'(1));
        $display("step: mulf / r0 sequence done");

        // WAIT handshake: low 10, high 3, then release
        rom_clear();
        rom[0] = enc(7, 0, 0, 0);
        rom[1] = enc(10, 0, 0, 0);
        SW = 10'h000;
        do_reset();
        tick(2);
        check("wait_entry_pc", 32'(pc), 32'(0));
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("wait_low_pc", 32'(pc), 32'(0));
        end
        SW[8] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("wait_high_pc", 32'(pc), 32'(0));
        end
        SW[8] = 1'b0;
        tick(1);
        check("wait_release_pc", 32'(pc), 32'(1));
        tick(2);
        check("wait_then_halt", 32'(halted), 32'(1));
        SW = 10'h100;
        do_reset();
        tick(3);
        check("wait_prepressed_pc", 32'(pc), 32'(0));
        SW[8] = 1'b0;
        tick(1);
        check("wait_prepressed_release", 32'(pc), 32'(1));
        $display("step: wait handshake done");

        // JMP / NOP wrap at 31, BZ taken and not taken
        rom_clear();
        SW = '0;
        rom[0]  = enc(9, 0, 0, 31);
        rom[31] = enc(9, 0, 0, 0);
        do_reset();
        tick(2);
        check("jmp_to_31", 32'(pc), 32'(31));
        tick(2);
        check("jmp_31_to_0", 32'(pc), 32'(0));
        rom[31] = enc(0, 0, 0, 0);
        tick(2);
        check("jmp_to_31_again", 32'(pc), 32'(31));
        tick(2);
        check("nop_wrap_0", 32'(pc), 32'(0));
        rom[0] = enc(8, 0, 0, 5);
        rom[5] = enc(2, 1, 0, 1);
        rom[6] = enc(8, 1, 0, 20);
        rom[7] = enc(8, 0, 0, 8'hE3);
        tick(2);
        check("bz_r0_taken", 32'(pc), 32'(5));
        tick(4);
        check("bz_not_taken", 32'(pc), 32'(7));
        tick(2);
        check("bz_imm_truncated", 32'(pc), 32'(3));
        $display("step: branch sequence done");

        // Random programs against the interpreter
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 32; i++) begin
                int op;
                op = int'($urandom_range(0, 15));
                while (op == 7 || op == 10) op = int'($urandom_range(0, 15));
                rom[i] = enc(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                             int'($urandom_range(0, 255)));
            end
            SW = '0;
            model_reset();
            do_reset();
            for (int k = 0; k < 40; k++) begin
                int old_pc;
                SW = {1'($urandom_range(0, 1)), 1'b0, 8'($urandom_range(0, 255))};
                old_pc = m_pc;
                model_step();
                tick(1);
                check("rand_fetch_pc", 32'(pc), 32'(old_pc));
                tick(1);
                check("rand_pc", 32'(pc), 32'(m_pc));
                check("rand_led", 32'(LED), 32'(m_led));
                check("rand_halted", 32'(halted), 32'(0));
                $display("rand t=%0d k=%0d pc=%0d->%0d led=%02h", t, k, old_pc, pc, LED);
            end
            for (int r = 0; r < 8; r++) begin
                for (int i = 0; i < 32; i++) rom[i] = enc(6, r, 0, 0);
                model_step();
                tick(2);
                check("rand_reg_dump", 32'(LED), 32'(m_led));
                $display("dump t=%0d r%0d led=%02h", t, r, LED);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
